// File: rtl/z80_io_cycle_gen.sv
`default_nettype none
// ============================================================================
//  Module      : z80_io_cycle_gen
//  Description : Bus initiator for Z80-style IN/OUT cycles on the E800J I/O
//                bus. Accepts one request on a valid/ready handshake, runs
//                T1/T2/TW/T3 with nWAIT stretching and a timeout abort, and
//                returns read data plus an error flag on a one-cycle strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module z80_io_cycle_gen #(
   parameter int WAIT_STATES = 1,    // automatic TW states, 1..7
   parameter int TIMEOUT     = 255   // nWAIT-low TW cycles tolerated, 1..255
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        REQ_VALID,
   output logic        REQ_READY,
   input  logic        REQ_WR,
   input  logic [15:0] REQ_ADDR,
   input  logic [7:0]  REQ_WDATA,
   output logic        RSP_VALID,
   output logic [7:0]  RSP_RDATA,
   output logic        RSP_ERR,
   output logic [15:0] A,
   output logic [7:0]  D_OUT,
   output logic        D_OE,
   input  logic [7:0]  D_IN,
   output logic        nIORQ,
   output logic        nRD,
   output logic        nWR,
   input  logic        nWAIT
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_T1   = 3'd1;
   localparam logic [2:0] S_T2   = 3'd2;
   localparam logic [2:0] S_TW   = 3'd3;
   localparam logic [2:0] S_T3   = 3'd4;

   localparam logic [2:0] WAIT_INIT = 3'(WAIT_STATES - 1);
   localparam logic [7:0] TO_LIMIT  = 8'(TIMEOUT);

   logic [2:0]  state_q, state_d;
   logic [2:0]  wait_q, wait_d;
   logic [7:0]  to_q, to_d;
   logic        err_q, err_d;
   logic        wr_q;
   logic [15:0] a_q;
   logic [7:0]  d_out_q;
   logic        d_oe_q;
   logic        niorq_q, nrd_q, nwr_q;
   logic        rsp_valid_q;
   logic [7:0]  rsp_rdata_q;
   logic        rsp_err_q;
   logic        accept;

   // Ready only in IDLE and never while reset is asserted.
   assign REQ_READY = nRST & (state_q == S_IDLE);
   assign accept    = REQ_VALID & REQ_READY;

   assign A         = a_q;
   assign D_OUT     = d_out_q;
   assign D_OE      = d_oe_q;
   assign nIORQ     = niorq_q;
   assign nRD       = nrd_q;
   assign nWR       = nwr_q;
   assign RSP_VALID = rsp_valid_q;
   assign RSP_RDATA = rsp_rdata_q;
   assign RSP_ERR   = rsp_err_q;

   // Next-state logic: T-state sequencing, wait-state countdown and timeout.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      to_d    = to_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: if (accept) state_d = S_T1;
         S_T1:   state_d = S_T2;
         S_T2: begin
            state_d = S_TW;
            wait_d  = WAIT_INIT;
            to_d    = 8'd0;
            err_d   = 1'b0;
         end
         S_TW: begin
            if (wait_q != 3'd0) begin
               wait_d = wait_q - 3'd1;
            end else if (nWAIT) begin
               state_d = S_T3;
            end else if (to_q == TO_LIMIT) begin
               // Peripheral held nWAIT low for the full allowance: abort.
               state_d = S_T3;
               err_d   = 1'b1;
            end else begin
               to_d = to_q + 8'd1;
            end
         end
         S_T3:    state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Registered state, bus drivers and response outputs.
   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q     <= S_IDLE;
         wait_q      <= 3'd0;
         to_q        <= 8'd0;
         err_q       <= 1'b0;
         wr_q        <= 1'b0;
         a_q         <= 16'h0000;
         d_out_q     <= 8'h00;
         d_oe_q      <= 1'b0;
         niorq_q     <= 1'b1;
         nrd_q       <= 1'b1;
         nwr_q       <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 8'h00;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         to_q        <= to_d;
         err_q       <= err_d;
         rsp_valid_q <= (state_q == S_T3);
         // Accept edge: set up T1 (address, and data drive for OUT).
         if (accept) begin
            wr_q    <= REQ_WR;
            a_q     <= REQ_ADDR;
            d_out_q <= REQ_WR ? REQ_WDATA : 8'h00;
            d_oe_q  <= REQ_WR;
         end
         // End of T1: assert IORQ and the direction strobe for T2 onwards.
         if (state_q == S_T1) begin
            niorq_q <= 1'b0;
            nrd_q   <= wr_q;
            nwr_q   <= ~wr_q;
         end
         // End of T3: release the bus and capture the response.
         if (state_q == S_T3) begin
            niorq_q     <= 1'b1;
            nrd_q       <= 1'b1;
            nwr_q       <= 1'b1;
            d_oe_q      <= 1'b0;
            rsp_err_q   <= err_q;
            rsp_rdata_q <= wr_q ? 8'h00 : (err_q ? 8'hFF : D_IN);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_z80_io_cycle_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_z80_io_cycle_gen
//  Description : Directed self-checking bench for z80_io_cycle_gen
//                (WAIT_STATES=1, TIMEOUT=4).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_z80_io_cycle_gen;

   localparam int TO = 4;

   logic        CLK = 1'b0;
   logic        nRST;
   logic        REQ_VALID;
   logic        REQ_READY;
   logic        REQ_WR;
   logic [15:0] REQ_ADDR;
   logic [7:0]  REQ_WDATA;
   logic        RSP_VALID;
   logic [7:0]  RSP_RDATA;
   logic        RSP_ERR;
   logic [15:0] A;
   logic [7:0]  D_OUT;
   logic        D_OE;
   logic [7:0]  D_IN;
   logic        nIORQ, nRD, nWR;
   logic        nWAIT;

   int checks   = 0;
   int failures = 0;

   z80_io_cycle_gen #(.WAIT_STATES(1), .TIMEOUT(TO)) dut (
      .CLK(CLK), .nRST(nRST),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WR(REQ_WR),
      .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
      .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR),
      .A(A), .D_OUT(D_OUT), .D_OE(D_OE), .D_IN(D_IN),
      .nIORQ(nIORQ), .nRD(nRD), .nWR(nWR), .nWAIT(nWAIT)
   );

   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   // One transfer from the accept cycle to its response cycle. nWAIT is low
   // from T1 for 2+nlow cycles, so TW sees nlow low samples (T1/T2 low must
   // be ignored). Returns positioned in the response cycle.
   task automatic do_txn(input string tag, input bit wr, input logic [15:0] addr,
                         input logic [7:0] wd, input logic [7:0] din,
                         input int nlow, input bit hold);
      bit   err;
      int   tw;
      bit   inbus;
      logic [7:0] exp_rd;
      err = (nlow > TO);
      tw  = err ? TO + 1 : nlow + 1;
      exp_rd = wr ? 8'h00 : (err ? 8'hFF : din);
      REQ_VALID = 1'b1;
      REQ_WR    = wr;
      REQ_ADDR  = addr;
      REQ_WDATA = wd;
      D_IN      = din;
      chk({tag, " ready_at_accept"}, REQ_READY, 1);
      step();
      for (int c = 1; c <= 4 + tw; c++) begin
         // Request lines change mid-cycle; these values must never be used.
         REQ_VALID = hold;
         REQ_WR    = ~wr;
         REQ_ADDR  = ~addr;
         REQ_WDATA = ~wd;
         nWAIT     = (c <= 2 + nlow) ? 1'b0 : 1'b1;
         inbus     = (c >= 2) && (c <= 3 + tw);
         chk($sformatf("%s c%0d A", tag, c), A, addr);
         chk($sformatf("%s c%0d nIORQ", tag, c), nIORQ, !inbus);
         chk($sformatf("%s c%0d nRD", tag, c), nRD, !(inbus && !wr));
         chk($sformatf("%s c%0d nWR", tag, c), nWR, !(inbus && wr));
         chk($sformatf("%s c%0d D_OE", tag, c), D_OE, wr && (c <= 3 + tw));
         if (wr && c <= 3 + tw)
            chk($sformatf("%s c%0d D_OUT", tag, c), D_OUT, wd);
         chk($sformatf("%s c%0d RSP_VALID", tag, c), RSP_VALID, c == 4 + tw);
         chk($sformatf("%s c%0d REQ_READY", tag, c), REQ_READY, c == 4 + tw);
         if (c == 4 + tw) begin
            chk({tag, " RSP_RDATA"}, RSP_RDATA, exp_rd);
            chk({tag, " RSP_ERR"}, RSP_ERR, err);
         end else begin
            step();
         end
      end
      nWAIT = 1'b1;
   endtask

   initial begin
      nRST = 1'b0; REQ_VALID = 1'b0; REQ_WR = 1'b0; REQ_ADDR = 16'h0;
      REQ_WDATA = 8'h0; D_IN = 8'h0; nWAIT = 1'b1;
      step(); step(); step();

      // Reset state
      chk("rst A", A, 16'h0000);
      chk("rst D_OUT", D_OUT, 8'h00);
      chk("rst D_OE", D_OE, 0);
      chk("rst nIORQ", nIORQ, 1);
      chk("rst nRD", nRD, 1);
      chk("rst nWR", nWR, 1);
      chk("rst RSP_VALID", RSP_VALID, 0);
      chk("rst RSP_RDATA", RSP_RDATA, 8'h00);
      chk("rst RSP_ERR", RSP_ERR, 0);
      chk("rst REQ_READY", REQ_READY, 0);
      nRST = 1'b1;
      step();
      chk("idle REQ_READY", REQ_READY, 1);

      // Plain read
      do_txn("rd00FE", 1'b0, 16'h00FE, 8'h00, 8'h5A, 0, 1'b0);
      step();
      chk("rd00FE pulse_end", RSP_VALID, 0);
      chk("rd00FE rdata_hold", RSP_RDATA, 8'h5A);
      chk("rd00FE strobes_idle", {nIORQ, nRD, nWR}, 3'b111);

      // Plain write
      do_txn("wr12F7", 1'b1, 16'h12F7, 8'hA5, 8'h33, 0, 1'b0);
      step();
      chk("wr12F7 D_OE_idle", D_OE, 0);

      // Read stretched by three nWAIT-low samples
      do_txn("rd00EE", 1'b0, 16'h00EE, 8'h00, 8'hC3, 3, 1'b0);
      step();

      // Exactly TIMEOUT low samples: still a normal completion
      do_txn("rdTOedge", 1'b0, 16'h0011, 8'h00, 8'h77, TO, 1'b0);
      step();

      // nWAIT stuck low: abort with error, data forced to 0xFF
      do_txn("rdStuck", 1'b0, 16'h0022, 8'h00, 8'h99, 100, 1'b0);
      step();
      chk("rdStuck pulse_end", RSP_VALID, 0);
      chk("rdStuck err_hold", RSP_ERR, 1);

      // Back-to-back with REQ_VALID held: second T1 in first response cycle
      do_txn("b2bRd", 1'b0, 16'h00BE, 8'h00, 8'h4C, 0, 1'b1);
      do_txn("b2bWr", 1'b1, 16'h00BF, 8'h6E, 8'h00, 0, 1'b0);
      step();
      chk("b2b pulse_end", RSP_VALID, 0);
      chk("b2b err_clear", RSP_ERR, 0);

      // Reset during TW of a write
      REQ_VALID = 1'b1; REQ_WR = 1'b1; REQ_ADDR = 16'h3456; REQ_WDATA = 8'h81;
      nWAIT = 1'b0;
      step();                      // T1
      REQ_VALID = 1'b0;
      step();                      // T2
      step();                      // TW (held by nWAIT low)
      chk("rstTW in_TW nWR", nWR, 0);
      nRST = 1'b0;
      step();
      chk("rstTW nWR", nWR, 1);
      chk("rstTW nIORQ", nIORQ, 1);
      chk("rstTW D_OE", D_OE, 0);
      chk("rstTW REQ_READY", REQ_READY, 0);
      chk("rstTW RSP_VALID", RSP_VALID, 0);
      step();
      chk("rstTW RSP_VALID2", RSP_VALID, 0);
      nRST = 1'b1; nWAIT = 1'b1;
      step();
      chk("rstTW released READY", REQ_READY, 1);
      chk("rstTW released RSP_VALID", RSP_VALID, 0);
      do_txn("postRst", 1'b0, 16'h00A0, 8'h00, 8'h3C, 0, 1'b0);
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
